lru_controller: RTL and testbench

LRU_CONTROLLER -- requirements
Module: lru_controller

---
 rtl/lru_controller_if.sv | 33 +++
 rtl/lru_controller.sv | 159 +++++++++++++++
 tb/tb_lru_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/lru_controller_if.sv
// Request/response and cell-array bus of the LRU controller.
// The master modport is the requester plus cell array; the slave modport is the controller.
interface lru_controller_if #(
  parameter int CELLS     = 4,
  parameter int ADDR_SIZE = 8
);
  localparam int W = $clog2(CELLS);

  logic                 req_valid;
  logic [ADDR_SIZE-1:0] req_tag;
  logic                 req_ready;
  logic                 flush;
  logic [ADDR_SIZE-1:0] cell_tag;
  logic [CELLS-1:0]     hit_vec;
  logic [CELLS-1:0]     cell_wen;
  logic                 resp_valid;
  logic                 resp_hit;
  logic [W-1:0]         resp_way;
  logic [15:0]          hit_count;
  logic [15:0]          miss_count;

  modport master (
    output req_valid, req_tag, flush, hit_vec,
    input  req_ready, cell_tag, cell_wen, resp_valid, resp_hit, resp_way,
           hit_count, miss_count
  );

  modport slave (
    input  req_valid, req_tag, flush, hit_vec,
    output req_ready, cell_tag, cell_wen, resp_valid, resp_hit, resp_way,
           hit_count, miss_count
  );
endinterface

// File: rtl/lru_controller.sv
// LRU replacement controller for a small fully-associative tag array.
// Define LRU_STATS_EN to build the saturating hit/miss statistics counters.
module lru_controller #(
  parameter int CELLS     = 4,
  parameter int ADDR_SIZE = 8
) (
  input logic             clk,
  input logic             reset,
  lru_controller_if.slave bus
);
  localparam int W = $clog2(CELLS);

  typedef enum logic [2:0] {IDLE, COMPARE, UPDATE, FILL, RESP} state_t;

  state_t               state_q, state_d;
  logic [CELLS-1:0]     valid_q, valid_d;
  logic [W-1:0]         age_q [CELLS];
  logic [W-1:0]         age_d [CELLS];
  logic [ADDR_SIZE-1:0] tag_q, tag_d;
  logic [W-1:0]         way_q, way_d;
  logic                 resp_hit_q, resp_hit_d;
  logic [W-1:0]         resp_way_q, resp_way_d;

  logic [CELLS-1:0]     hv;
  logic [W-1:0]         hit_idx;
  logic [W-1:0]         victim;
  logic [W-1:0]         upd_way;
  logic                 req_ready_c;
  logic                 resp_valid_c;
  logic [CELLS-1:0]     cell_wen_c;

  assign hv = bus.hit_vec & valid_q;

  // Lowest matching way wins when several cells report a hit.
  always_comb begin
    hit_idx = '0;
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (hv[i]) hit_idx = W'(i);
    end
  end

  // Prefer the lowest empty cell; only evict the oldest entry when the set is full.
  always_comb begin
    victim = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (age_q[i] == W'(CELLS - 1)) victim = W'(i);
    end
    if (!(&valid_q)) begin
      for (int j = CELLS - 1; j >= 0; j--) begin
        if (!valid_q[j]) victim = W'(j);
      end
    end
  end

  assign upd_way = (state_q == FILL) ? victim : way_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    age_d        = age_q;
    tag_d        = tag_q;
    way_d        = way_q;
    resp_hit_d   = resp_hit_q;
    resp_way_d   = resp_way_q;
    req_ready_c  = 1'b0;
    resp_valid_c = 1'b0;
    cell_wen_c   = '0;

    case (state_q)
      IDLE: begin
        req_ready_c = !bus.flush;
        if (bus.flush) begin
          valid_d = '0;
        end else if (bus.req_valid) begin
          tag_d   = bus.req_tag;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        way_d   = hit_idx;
        state_d = (|hv) ? UPDATE : FILL;
      end
      UPDATE, FILL: begin
        // Younger entries age by one; the touched way becomes most recent.
        for (int i = 0; i < CELLS; i++) begin
          if (age_q[i] < age_q[upd_way]) age_d[i] = age_q[i] + 1'b1;
        end
        age_d[upd_way] = '0;
        resp_way_d     = upd_way;
        resp_hit_d     = (state_q == UPDATE);
        if (state_q == FILL) begin
          cell_wen_c      = CELLS'(1) << victim;
          valid_d[victim] = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid_c = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      tag_q      <= '0;
      way_q      <= '0;
      resp_hit_q <= 1'b0;
      resp_way_q <= '0;
      for (int i = 0; i < CELLS; i++) age_q[i] <= W'(CELLS - 1 - i);
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      way_q      <= way_d;
      resp_hit_q <= resp_hit_d;
      resp_way_q <= resp_way_d;
      age_q      <= age_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.cell_wen   = cell_wen_c;
  assign bus.cell_tag   = tag_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_way   = resp_way_q;

`ifdef LRU_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == UPDATE && hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
    if (state_q == FILL && miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif
endmodule

// File: tb/tb_lru_controller.sv
// Directed bench for lru_controller with CELLS=4, ADDR_SIZE=8.
// Expected ways follow a hand-traced LRU age table for each vector.
module tb_lru_controller;
  logic clk = 1'b0;
  logic reset;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   exp_hits     = 0;
  int   exp_misses   = 0;

  always #5 clk = ~clk;

  lru_controller_if #(.CELLS(4), .ADDR_SIZE(8)) bus ();

  lru_controller #(.CELLS(4), .ADDR_SIZE(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCounters(input string tag);
`ifdef LRU_STATS_EN
    checkOutput({tag, "_hit_count"}, 32'(bus.hit_count), 32'(exp_hits));
    checkOutput({tag, "_miss_count"}, 32'(bus.miss_count), 32'(exp_misses));
`else
    checkOutput({tag, "_hit_count"}, 32'(bus.hit_count), 32'd0);
    checkOutput({tag, "_miss_count"}, 32'(bus.miss_count), 32'd0);
`endif
  endtask

  // Entered and left at 1 time unit after a rising edge with the controller in IDLE.
  task automatic applyStimulus(input string name, input logic [7:0] tag, input logic [3:0] hv,
                               input bit with_flush, input bit exp_hit,
                               input logic [1:0] exp_way);
    int         cycles;
    int         wen_cycles;
    logic [3:0] wen_seen;
    logic [3:0] exp_wen;
    bus.req_tag   = tag;
    bus.hit_vec   = hv;
    bus.req_valid = 1'b1;
    if (with_flush) begin
      bus.flush = 1'b1;
      #1 checkOutput({name, "_ready_with_flush"}, 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1 bus.flush = 1'b0;
    end
    #1 checkOutput({name, "_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    checkOutput({name, "_cell_tag"}, 32'(bus.cell_tag), 32'(tag));
    cycles     = 1;
    wen_cycles = 0;
    wen_seen   = '0;
    while (!bus.resp_valid && cycles < 10) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.cell_wen != 4'b0) begin
        wen_cycles++;
        wen_seen |= bus.cell_wen;
      end
    end
    exp_wen = exp_hit ? 4'b0000 : (4'b0001 << exp_way);
    checkOutput({name, "_latency"}, 32'(cycles), 32'd3);
    checkOutput({name, "_resp_hit"}, 32'(bus.resp_hit), 32'(exp_hit));
    checkOutput({name, "_resp_way"}, 32'(bus.resp_way), 32'(exp_way));
    checkOutput({name, "_cell_wen"}, 32'(wen_seen), 32'(exp_wen));
    checkOutput({name, "_wen_cycles"}, 32'(wen_cycles), exp_hit ? 32'd0 : 32'd1);
    if (exp_hit) exp_hits++;
    else exp_misses++;
    @(posedge clk);
    #1;
    checkOutput({name, "_resp_pulse_end"}, 32'(bus.resp_valid), 32'd0);
    checkOutput({name, "_resp_way_hold"}, 32'(bus.resp_way), 32'(exp_way));
    checkOutput({name, "_resp_hit_hold"}, 32'(bus.resp_hit), 32'(exp_hit));
  endtask

  initial begin
    int         abort_events;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_tag   = 8'h00;
    bus.flush     = 1'b0;
    bus.hit_vec   = 4'b0000;

    #1;
    checkOutput("rst_cell_tag", 32'(bus.cell_tag), 32'd0);
    checkOutput("rst_cell_wen", 32'(bus.cell_wen), 32'd0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_resp_hit", 32'(bus.resp_hit), 32'd0);
    checkOutput("rst_resp_way", 32'(bus.resp_way), 32'd0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkCounters("rst");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Cold fills: empty cells are taken lowest index first. Ages end as [3,2,1,0].
    applyStimulus("fill0", 8'h10, 4'b0000, 1'b0, 1'b0, 2'd0);
    applyStimulus("fill1", 8'h11, 4'b0000, 1'b0, 1'b0, 2'd1);
    applyStimulus("fill2", 8'h12, 4'b0000, 1'b0, 1'b0, 2'd2);
    applyStimulus("fill3", 8'h13, 4'b0000, 1'b0, 1'b0, 2'd3);
    // Hit way0 -> ages [0,3,2,1]; next miss evicts way1 -> ages [1,0,3,2].
    applyStimulus("hit0", 8'h10, 4'b0001, 1'b0, 1'b1, 2'd0);
    applyStimulus("evict1", 8'h20, 4'b0000, 1'b0, 1'b0, 2'd1);
    // Multi-hit picks the lowest way; way1 is already youngest so ages stay.
    applyStimulus("multihit", 8'h20, 4'b0110, 1'b0, 1'b1, 2'd1);
    applyStimulus("evict2", 8'h21, 4'b0000, 1'b0, 1'b0, 2'd2);
    // Flush together with a request: flush first, then all-ones hit_vec is a miss.
    applyStimulus("flush_fill0", 8'h30, 4'b1111, 1'b1, 1'b0, 2'd0);
    applyStimulus("fill1b", 8'h31, 4'b0000, 1'b0, 1'b0, 2'd1);
    applyStimulus("hit1", 8'h31, 4'b0010, 1'b0, 1'b1, 2'd1);
    checkCounters("pre_abort");

    // Reset while the request sits in COMPARE.
    bus.req_tag   = 8'h55;
    bus.hit_vec   = 4'b0000;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    exp_hits   = 0;
    exp_misses = 0;
    checkOutput("abort_cell_tag", 32'(bus.cell_tag), 32'd0);
    checkOutput("abort_cell_wen", 32'(bus.cell_wen), 32'd0);
    checkOutput("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("abort_resp_hit", 32'(bus.resp_hit), 32'd0);
    checkOutput("abort_resp_way", 32'(bus.resp_way), 32'd0);
    checkCounters("abort");
    @(posedge clk);
    #1 reset = 1'b0;
    abort_events = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid || bus.cell_wen != 4'b0) abort_events++;
    end
    checkOutput("abort_no_activity", 32'(abort_events), 32'd0);

    // Two misses then three hits from a fresh reset.
    applyStimulus("post_fill0", 8'h40, 4'b0000, 1'b0, 1'b0, 2'd0);
    applyStimulus("post_fill1", 8'h41, 4'b0000, 1'b0, 1'b0, 2'd1);
    applyStimulus("post_hit1", 8'h41, 4'b0010, 1'b0, 1'b1, 2'd1);
    applyStimulus("post_hit0", 8'h40, 4'b0001, 1'b0, 1'b1, 2'd0);
    applyStimulus("post_hit01", 8'h40, 4'b0011, 1'b0, 1'b1, 2'd0);
    checkCounters("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
